// File: rtl/key_conditioner.sv
// Key input conditioner: synchronises and debounces a raw key level and emits one pulse per press.
// Optional build macro KEY_AUTOREPEAT_EN adds periodic repeat pulses while the key is held.
module key_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic clk,
  input  logic n_reset,
  input  logic key_raw,
  output logic A,
  output logic level,
  output logic pending
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] DEB_CNT = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    REL   = 2'd0,
    CHK_P = 2'd1,
    PRS   = 2'd2,
    CHK_R = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   ks;
  state_t                 state;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_inc;

  // Each synchroniser stage is its own flop so the chain length follows SYNC_STAGES.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge n_reset) begin
          if (!n_reset) sync_reg[gi] <= 1'b0;
          else          sync_reg[gi] <= key_raw;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge n_reset) begin
          if (!n_reset) sync_reg[gi] <= 1'b0;
          else          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign ks        = sync_reg[SYNC_STAGES-1];
  assign count_inc = (count == CNT_MAX) ? count : count + CNT_ONE;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= REL;
      count   <= '0;
      A       <= 1'b0;
      level   <= 1'b0;
      pending <= 1'b0;
    end else begin
      A <= 1'b0;
      case (state)
        REL: begin
          level   <= 1'b0;
          pending <= 1'b0;
          if (ks) begin
            state   <= CHK_P;
            count   <= CNT_ONE;
            pending <= 1'b1;
          end
        end

        CHK_P: begin
          if (!ks) begin
            state   <= REL;
            count   <= '0;
            pending <= 1'b0;
          end else if (count == DEB_CNT) begin
            state   <= PRS;
            count   <= '0;
            level   <= 1'b1;
            A       <= 1'b1;
            pending <= 1'b0;
          end else begin
            count <= count_inc;
          end
        end

        PRS: begin
          level   <= 1'b1;
          pending <= 1'b0;
          if (!ks) begin
            state   <= CHK_R;
            count   <= CNT_ONE;
            pending <= 1'b1;
          end else begin
`ifdef KEY_AUTOREPEAT_EN
            // Counter measures the hold time; A fires in the edge the count reaches the period.
            if (count >= CW'(REPEAT_CYCLES)) begin
              count <= CNT_ONE;
            end else begin
              count <= count_inc;
              if (count == CW'(REPEAT_CYCLES - 1)) A <= 1'b1;
            end
`else
            count <= '0;
`endif
          end
        end

        CHK_R: begin
          if (ks) begin
            state   <= PRS;
            count   <= '0;
            pending <= 1'b0;
          end else if (count == DEB_CNT) begin
            state   <= REL;
            count   <= '0;
            level   <= 1'b0;
            pending <= 1'b0;
          end else begin
            count <= count_inc;
          end
        end

        default: begin
          state   <= REL;
          count   <= '0;
          level   <= 1'b0;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule
